// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan block and the BCD decoder.
// Patterns are active-low, bit 6 = segment a ... bit 0 = segment g.
package seg_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h01;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h4C;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h20;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h0F;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h04;

    // Non-decimal codes map to blank rather than to a hex glyph.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] d);
        logic [SEG_W-1:0] p;
        p = SEG_BLANK;
        unique case (d)
            4'd0: p = SEG_0;
            4'd1: p = SEG_1;
            4'd2: p = SEG_2;
            4'd3: p = SEG_3;
            4'd4: p = SEG_4;
            4'd5: p = SEG_5;
            4'd6: p = SEG_6;
            4'd7: p = SEG_7;
            4'd8: p = SEG_8;
            4'd9: p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot-rate prescaler: counts 0..DIV-1 and flags the last cycle of a slot.
module seg_prescaler #(
    parameter int DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [$clog2(DIV)-1:0] cnt,
    output logic                   tick
);

    localparam int CW = $clog2(DIV);

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner with a frame-atomic shadow buffer.
// Define SEG_SCAN_DEADTIME_EN to blank the anodes for DEAD cycles per slot.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 50000,
    parameter int DEAD       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_valid,
    input  logic [SEG_W*NUM_DIGITS-1:0] frame_data,
    output logic                        frame_ready,
    output logic [SEG_W-1:0]            seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_tick
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = SEG_W * NUM_DIGITS;

`ifdef SEG_SCAN_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic [CW-1:0] cnt;
    logic          tick;
    logic          wrap;
    logic          xfer;
    logic          blank;
    logic          pending;
    logic [IW-1:0] idx;
    logic [FW-1:0] shadow;
    logic [FW-1:0] disp;

    seg_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .tick  (tick)
    );

    assign wrap        = tick && (idx == IW'(NUM_DIGITS - 1));
    assign frame_ready = !pending;
    assign xfer        = frame_valid && !pending;
    assign blank       = DT_EN && (cnt < CW'(DEAD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= wrap ? '0 : idx + 1'b1;
        end
    end

    // Commit and accept are exclusive: a wrap-cycle transfer waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            shadow  <= {NUM_DIGITS{SEG_BLANK}};
            disp    <= {NUM_DIGITS{SEG_BLANK}};
        end else if (wrap && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
        end else if (xfer) begin
            shadow  <= frame_data;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= disp[int'(idx)*SEG_W +: SEG_W];
            an         <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Randomised bench for seg_scan against a slot/frame-position model.
// Build with or without SEG_SCAN_DEADTIME_EN; the model follows the macro.
module tb_seg_scan;

    localparam int ND   = 4;
    localparam int DV   = 4;
    localparam int DD   = 1;
    localparam int SCAN = ND * DV;

`ifdef SEG_SCAN_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [27:0] frame_data = '0;
    logic        frame_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    int         t;
    logic [6:0] m_disp [ND];
    logic [6:0] m_shadow [ND];
    bit         m_pend;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_tick;

    seg_scan #(
        .NUM_DIGITS (ND),
        .DIV        (DV),
        .DEAD       (DD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .seg         (seg),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        t = 0;
        m_pend = 1'b0;
        for (int k = 0; k < ND; k++) begin
            m_disp[k] = 7'h7F;
            m_shadow[k] = 7'h7F;
        end
    endtask

    // One clock: drive inputs, predict outputs from scan position, advance.
    task automatic cycle(input logic v, input logic [27:0] d);
        int c;
        int slot;
        logic [3:0] one;
        one = 4'b0001;
        c = t % SCAN;
        slot = c / DV;
        frame_valid = v;
        frame_data = d;
        e_seg = m_disp[slot];
        e_an = ~(one << slot);
        if (DT && (c % DV) < DD) e_an = 4'hF;
        e_tick = (c == SCAN - 1);
        if (e_tick && m_pend) begin
            for (int k = 0; k < ND; k++) m_disp[k] = m_shadow[k];
            m_pend = 1'b0;
        end else if (v && !m_pend) begin
            for (int k = 0; k < ND; k++) m_shadow[k] = d[7*k +: 7];
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({seg, an, frame_ready, frame_tick} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset seg=%h an=%b rdy=%b tick=%b want 7f 1111 1 0",
                     seg, an, frame_ready, frame_tick);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_scan();
        for (int i = 0; i < 2 * SCAN; i++) begin
            cycle(1'b0, '0);
            checks++;
            if ({seg, an, frame_ready, frame_tick} !== {e_seg, e_an, !m_pend, e_tick}) begin
                failures++;
                $display("FAIL idle t=%0d got %h %b %b %b want %h %b %b %b", t,
                         seg, an, frame_ready, frame_tick, e_seg, e_an, !m_pend, e_tick);
            end
        end
    endtask

    task automatic test_frame_midscan();
        logic [27:0] f;
        f = {7'h4F, 7'h12, 7'h4F, 7'h01};
        for (int i = 0; i < 2 * SCAN + 6; i++) begin
            cycle(i == 6, (i == 6) ? f : 28'(0));
            checks++;
            if ({seg, an, frame_ready, frame_tick} !== {e_seg, e_an, !m_pend, e_tick}) begin
                failures++;
                $display("FAIL midscan t=%0d got %h %b %b %b want %h %b %b %b", t,
                         seg, an, frame_ready, frame_tick, e_seg, e_an, !m_pend, e_tick);
            end
        end
        checks++;
        if (m_disp[0] !== 7'h01 || m_disp[1] !== 7'h4F) begin
            failures++;
            $display("FAIL midscan_disp got %h %h want 01 4f", m_disp[0], m_disp[1]);
        end
    endtask

    task automatic test_busy();
        logic [27:0] d;
        int c;
        while ((t % SCAN) != 2) cycle(1'b0, '0);
        for (int i = 0; i < 2 * SCAN; i++) begin
            c = t % SCAN;
            d = 28'($urandom);
            cycle(i < SCAN && c != SCAN - 1, d);
            checks++;
            if ({seg, an, frame_ready, frame_tick} !== {e_seg, e_an, !m_pend, e_tick}) begin
                failures++;
                $display("FAIL busy t=%0d got %h %b %b %b want %h %b %b %b", t,
                         seg, an, frame_ready, frame_tick, e_seg, e_an, !m_pend, e_tick);
            end
        end
    endtask

    task automatic test_wrap_xfer();
        int ticks;
        for (int i = 0; i < 3 * SCAN && (m_pend || (t % SCAN) != SCAN - 1); i++)
            cycle(1'b0, '0);
        cycle(1'b1, 28'($urandom));
        ticks = int'(frame_tick);
        for (int i = 0; i < 2 * SCAN; i++) begin
            cycle(1'b0, '0);
            if (i < SCAN) ticks += int'(frame_tick);
            checks++;
            if ({seg, an, frame_ready, frame_tick} !== {e_seg, e_an, !m_pend, e_tick}) begin
                failures++;
                $display("FAIL wrap_xfer t=%0d got %h %b %b %b want %h %b %b %b", t,
                         seg, an, frame_ready, frame_tick, e_seg, e_an, !m_pend, e_tick);
            end
        end
        checks++;
        if (ticks !== 2) begin
            failures++;
            $display("FAIL wrap_ticks got %0d want 2", ticks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10 * SCAN; i++) begin
            cycle($urandom_range(0, 3) == 0, 28'($urandom));
            checks++;
            if ({seg, an, frame_ready, frame_tick} !== {e_seg, e_an, !m_pend, e_tick}) begin
                failures++;
                $display("FAIL random t=%0d got %h %b %b %b want %h %b %b %b", t,
                         seg, an, frame_ready, frame_tick, e_seg, e_an, !m_pend, e_tick);
            end
        end
    endtask

    task automatic test_reset_pending();
        for (int i = 0; i < 3 * SCAN && (m_pend || (t % SCAN) != 4); i++)
            cycle(1'b0, '0);
        cycle(1'b1, 28'($urandom));
        cycle(1'b0, '0);
        frame_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({seg, an, frame_ready, frame_tick} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_async got %h %b %b %b want 7f 1111 1 0",
                     seg, an, frame_ready, frame_tick);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * SCAN; i++) begin
            cycle(1'b0, '0);
            checks++;
            if ({seg, an, frame_ready, frame_tick} !== {e_seg, e_an, !m_pend, e_tick}) begin
                failures++;
                $display("FAIL rst_pend t=%0d got %h %b %b %b want %h %b %b %b", t,
                         seg, an, frame_ready, frame_tick, e_seg, e_an, !m_pend, e_tick);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_scan();
        test_frame_midscan();
        test_busy();
        test_wrap_xfer();
        test_random();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of time-multiplexed digits; legal range 2..8.
REQ-002 Parameter DIV, default 50000: clk cycles per digit slot; legal range >= 2.
REQ-003 Parameter DEAD, default 4: blanking cycles at the start of each slot; legal range 1..DIV-1; used only with SEG_SCAN_DEADTIME_EN.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 frame_valid  input  1  a new frame is offered.
REQ-007 frame_data  input  7*NUM_DIGITS  segment patterns; digit k occupies bits [7k+6:7k]; active-low; bit 6 = segment a, bit 0 = segment g.
REQ-008 frame_ready  output  1  the shadow buffer can accept a frame.
REQ-009 seg  output  7  active-low segment lines shared by all digits.
REQ-010 an  output  NUM_DIGITS  active-low digit enables; at most one bit low at a time.
REQ-011 frame_tick  output  1  one-cycle pulse on each scan wrap.

Function
REQ-012 A prescaler cnt SHALL count 0..DIV-1 and wrap; tick = (cnt == DIV-1).
REQ-013 Digit index idx SHALL advance by 1 on tick and wrap from NUM_DIGITS-1 to 0.
REQ-014 seg and an SHALL be registered: one cycle after idx changes, seg = disp[idx] and an = ~(1 << idx).
REQ-015 A transfer occurs on a cycle where frame_valid && frame_ready: shadow <= frame_data and pending <= 1.
REQ-016 frame_ready SHALL equal !pending; it has no combinational path from frame_valid.
REQ-017 wrap = tick && idx == NUM_DIGITS-1; on wrap with pending = 1: disp <= shadow and pending <= 0.
REQ-018 A transfer in the same cycle as wrap (pending was 0) SHALL NOT commit that cycle; it commits at the next wrap, so no torn frames are shown.
REQ-019 frame_tick SHALL be high for exactly the cycle after wrap.
REQ-020 frame_valid while frame_ready = 0 SHALL be ignored; the upstream holds its data until it sees ready.

Reset
REQ-021 On rst_n low, asynchronously:
- cnt = 0, idx = 0, pending = 0
- disp and shadow all ones (blank)
- seg = 7'h7F, an = all ones, frame_tick = 0
REQ-022 On the first edge after rst_n deasserts, an SHALL select digit 0 with a blank pattern.
REQ-023 Reset asserted mid-frame SHALL discard the pending frame and the display contents.

Configuration
REQ-024 Macro SEG_SCAN_DEADTIME_EN defined: while cnt < DEAD, an SHALL be all ones (anti-ghosting), with seg already driving the new digit.
REQ-025 Macro SEG_SCAN_DEADTIME_EN undefined: an is never forced blank, and DEAD is unused.

Structure
REQ-026 Package seg_pkg SHALL hold:
- SEG_W = 7
- SEG_BLANK = 7'h7F
- the digit-pattern constants for 0-9 shared with the BCD decoder
REQ-027 The prescaler SHALL be a sub-module, seg_prescaler (parameter DIV, output tick).

Verification (bench: NUM_DIGITS = 4, DIV = 4, DEAD = 1)
REQ-028 Reset released, no frame sent -> seg = 7'h7F on every cycle; an steps 1110, 1101, 1011, 0111 every 4 cycles.
REQ-029 Frame {d3..d0} = {7'h4F, 7'h12, 7'h4F, 7'h01} accepted mid-scan -> blank until the next wrap, then digit 0 = 7'h01 and digit 1 = 7'h4F (the "1" pattern); frame_ready low until that wrap.
REQ-030 Second frame offered while pending = 1 -> frame_ready = 0 and the first frame is displayed unchanged.
REQ-031 frame_valid asserted exactly on the wrap cycle -> pending = 1 for a full scan; commit occurs one frame later; frame_tick pulses twice in between.
REQ-032 With SEG_SCAN_DEADTIME_EN defined -> an = 1111 for 1 cycle at each slot start; without it -> never 1111 after reset.
REQ-033 rst_n pulsed low for 1 cycle mid-slot with pending = 1 -> outputs blank immediately; the pending frame is never shown.
